// File: rtl/riscv_alu_pkg.sv
// riscv_alu_pkg
//   Shared definitions for the pipelined execute unit: opcode encodings,
//   the status-flag bundle carried alongside each result, and a legality
//   helper for opcode decoding.
package riscv_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_SLTU;
  endfunction

endpackage

// File: rtl/riscv_alu_pipe_if.sv
// riscv_alu_pipe_if
//   Handshake bundle for the execute unit.
//   Upstream side : in_valid/in_ready, opcode, operand1, operand2
//   Downstream side: out_valid/out_ready, result, flags, res_tag
//   slave  modport: the execute unit itself
//   master modport: the decode/writeback environment around it
interface riscv_alu_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             neg_flag;
  logic             carry_flag;
  logic             ovf_flag;
  logic             illegal_op;
  logic [TAG_W-1:0] res_tag;

  modport slave (
    input  in_valid, opcode, operand1, operand2, out_ready,
    output in_ready, out_valid, result, zero_flag, neg_flag,
           carry_flag, ovf_flag, illegal_op, res_tag
  );

  modport master (
    output in_valid, opcode, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, zero_flag, neg_flag,
           carry_flag, ovf_flag, illegal_op, res_tag
  );
endinterface

// File: rtl/riscv_alu_core.sv
// riscv_alu_core
//   Purely combinational ALU: maps opcode and operands to a result and
//   status flags.
//   opcode_i : operation select (10..15 illegal)
//   a_i, b_i : operands A and B
//   result_o : ALU result (0 for illegal opcodes)
//   flags_o  : zero/neg/carry/ovf/illegal
module riscv_alu_core
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       opcode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic             borrow;
  logic             slt_s;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             illegal;

  assign sum    = {1'b0, a_i} + {1'b0, b_i};
  assign diff   = {1'b0, a_i} - {1'b0, b_i};
  assign borrow = diff[WIDTH];
  assign shamt  = b_i[SHW-1:0];
  // Differing signs decide the signed compare directly; otherwise the
  // unsigned borrow gives the answer.
  assign slt_s  = (a_i[WIDTH-1] != b_i[WIDTH-1]) ? a_i[WIDTH-1] : borrow;

  always_comb begin
    res     = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = borrow;
        ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_SLL:  res = a_i << shamt;
      OP_SRL:  res = a_i >> shamt;
      OP_SRA:  res = $unsigned($signed(a_i) >>> shamt);
      OP_SLT: begin
        res   = {{(WIDTH-1){1'b0}}, slt_s};
        carry = borrow;
      end
      OP_SLTU: begin
        res   = {{(WIDTH-1){1'b0}}, borrow};
        carry = borrow;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign result_o        = res;
  assign flags_o.zero    = !illegal && (res == '0);
  assign flags_o.neg     = res[WIDTH-1];
  assign flags_o.carry   = carry;
  assign flags_o.ovf     = ovf;
  assign flags_o.illegal = illegal;

endmodule

// File: rtl/riscv_alu_pipe.sv
// riscv_alu_pipe
//   Two-stage pipelined execute unit with valid/ready on both sides.
//   S1 holds the accepted instruction and its sequence tag; S2 holds the
//   computed result, flags and tag and drives the output side.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; flushes both stages and the tag
//   bus   : handshake bundle (slave side)
module riscv_alu_pipe
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 16
) (
  input logic             clk,
  input logic             reset,
  riscv_alu_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic [TAG_W-1:0] tag_cnt_q,  tag_cnt_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q,   s2_res_d;
  alu_flags_t       s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;
  logic             s1_adv;
  logic             in_ready;
  logic             accept;

  riscv_alu_core #(.WIDTH(WIDTH)) u_core (
    .opcode_i (s1_op_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  // S1 may move on when S2 is empty or is being drained this cycle; this
  // makes in_ready combinationally dependent on out_ready.
  assign s1_adv   = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign in_ready = !reset && (!s1_valid_q || s1_adv);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    tag_cnt_d  = tag_cnt_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.opcode;
      s1_a_d     = bus.operand1;
      s1_b_d     = bus.operand2;
      s1_tag_d   = tag_cnt_q;
      tag_cnt_d  = tag_cnt_q + 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_res_d   = core_res;
      s2_flags_d = core_flags;
      s2_tag_d   = s1_tag_q;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      tag_cnt_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      tag_cnt_q  <= tag_cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = s2_valid_q;
  assign bus.result     = s2_res_q;
  assign bus.zero_flag  = s2_flags_q.zero;
  assign bus.neg_flag   = s2_flags_q.neg;
  assign bus.carry_flag = s2_flags_q.carry;
  assign bus.ovf_flag   = s2_flags_q.ovf;
  assign bus.illegal_op = s2_flags_q.illegal;
  assign bus.res_tag    = s2_tag_q;

endmodule

// File: tb/tb_riscv_alu_pipe.sv
module tb_riscv_alu_pipe;
  import riscv_alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  riscv_alu_pipe_if #(.WIDTH(16), .TAG_W(4))  bus16 ();
  riscv_alu_pipe_if #(.WIDTH(32), .TAG_W(16)) bus32 ();

  riscv_alu_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .reset(reset), .bus(bus16.slave));
  riscv_alu_pipe #(.WIDTH(32), .TAG_W(16)) u32 (
    .clk(clk), .reset(reset), .bus(bus32.slave));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;   // {illegal, ovf, carry, neg, zero}
    int          tag;
    int          acc_step;
    bit          lat;
  } sb_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic [4:0]  fl;
  } dir_t;

  sb_t  sb[$];
  int   n_tests = 0, n_fail = 0;
  int   tag_model = 0, step_no = 0, n_acc = 0;
  bit   dir_pend = 0;
  sb_t  dir_exp;
  bit   hold_v = 0;
  logic [15:0] hold_res;
  logic [3:0]  hold_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model computed with wide integer arithmetic.
  function automatic sb_t model(input int w, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b);
    sb_t m;
    longint unsigned mask, ua, ub, r, s;
    longint sa_v, sb_v;
    int sh;
    logic c, v, ill, asg, bsg;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    asg = ua[w-1];
    bsg = ub[w-1];
    sh = int'(ub % longint'(w));
    sa_v = asg ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb_v = bsg ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    c = 0; v = 0; ill = 0; r = 0;
    case (op)
      4'd0: begin s = ua + ub; r = s & mask; c = (s >> w) != 0;
                  v = (asg == bsg) && (r[w-1] != asg); end
      4'd1: begin r = (ua - ub) & mask; c = ua < ub;
                  v = (asg != bsg) && (r[w-1] != asg); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (ua << sh) & mask;
      4'd6: r = ua >> sh;
      4'd7: r = $unsigned(sa_v >>> sh) & mask;
      4'd8: begin r = (sa_v < sb_v) ? 1 : 0; c = ua < ub; end
      4'd9: begin r = (ua < ub) ? 1 : 0; c = ua < ub; end
      default: ill = 1;
    endcase
    m.res = r[31:0];
    m.fl = {ill, v, c, r[w-1], (!ill && r == 0)};
    m.tag = 0; m.acc_step = 0; m.lat = 0;
    return m;
  endfunction

  // One cycle on the 16-bit unit: drive at negedge, settle, then score the
  // transfers that the following posedge will commit.
  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic ordy);
    sb_t e;
    logic s1_full;
    @(negedge clk);
    step_no++;
    bus16.in_valid = v; bus16.opcode = op;
    bus16.operand1 = a; bus16.operand2 = b;
    bus16.out_ready = ordy;
    #1;
    if (hold_v) begin
      check("stall_valid", bus16.out_valid, 1);
      check("stall_result", bus16.result, hold_res);
      check("stall_tag", bus16.res_tag, hold_tag);
    end
    s1_full = (sb.size() - int'(bus16.out_valid)) == 1;
    check("in_ready", bus16.in_ready, !reset && !(s1_full && bus16.out_valid && !ordy));
    if (bus16.out_valid && ordy) begin
      check("out_expected", bus16.out_valid, sb.size() > 0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", bus16.result, e.res);
        check("flags", {bus16.illegal_op, bus16.ovf_flag, bus16.carry_flag,
                        bus16.neg_flag, bus16.zero_flag}, e.fl);
        check("res_tag", bus16.res_tag, e.tag);
        if (e.lat) check("latency", step_no - e.acc_step, 2);
      end
    end
    hold_v = bus16.out_valid && !ordy && !reset;
    hold_res = bus16.result;
    hold_tag = bus16.res_tag;
    if (v && bus16.in_ready) begin
      e = dir_pend ? dir_exp : model(16, op, {16'd0, a}, {16'd0, b});
      e.tag = tag_model;
      e.acc_step = step_no;
      e.lat = dir_pend;
      sb.push_back(e);
      tag_model = (tag_model + 1) % 16;
      n_acc++;
      dir_pend = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    bus16.in_valid = 0; bus16.out_ready = 0;
    bus32.in_valid = 0; bus32.out_ready = 0;
    @(negedge clk);
    #1;
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_in_ready", bus16.in_ready, 0);
    sb.delete();
    tag_model = 0;
    hold_v = 0;
    reset = 0;
  endtask

  task automatic stream(input int n_ops);
    int start, guard;
    start = n_acc;
    guard = 0;
    while (n_acc - start < n_ops && guard < 300) begin
      step(1, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)));
      guard++;
    end
    check("stream_accepted", n_acc - start, n_ops);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() > 0 || bus16.out_valid) && guard < 50) begin
      step(0, 0, 0, 0, 1);
      guard++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  dir_t dtab[10] = '{
    '{4'd0,  32'h7FFF, 32'h0001, 32'h8000, 5'b01010},
    '{4'd1,  32'h0003, 32'h0005, 32'hFFFE, 5'b00110},
    '{4'd1,  32'h0005, 32'h0005, 32'h0000, 5'b00001},
    '{4'd7,  32'h8000, 32'h0014, 32'hF800, 5'b00010},
    '{4'd8,  32'hFFFF, 32'h0001, 32'h0001, 5'b00000},
    '{4'd9,  32'hFFFF, 32'h0001, 32'h0000, 5'b00001},
    '{4'd12, 32'h1234, 32'h5678, 32'h0000, 5'b10000},
    '{4'd5,  32'h0001, 32'h0013, 32'h0008, 5'b00000},
    '{4'd6,  32'h8000, 32'h000F, 32'h0001, 5'b00000},
    '{4'd4,  32'hFF00, 32'h0F0F, 32'hF00F, 5'b00010}
  };

  dir_t wtab[3] = '{
    '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b00101},
    '{4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b00110},
    '{4'd7, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 5'b00010}
  };

  initial begin
    bus16.in_valid = 0; bus16.opcode = 0; bus16.operand1 = 0;
    bus16.operand2 = 0; bus16.out_ready = 0;
    bus32.in_valid = 0; bus32.opcode = 0; bus32.operand1 = 0;
    bus32.operand2 = 0; bus32.out_ready = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_result", bus16.result, 0);
    check("rst_flags", {bus16.illegal_op, bus16.ovf_flag, bus16.carry_flag,
                        bus16.neg_flag, bus16.zero_flag}, 0);
    check("rst_tag", bus16.res_tag, 0);
    check("rst_in_ready", bus16.in_ready, 0);
    reset = 0;

    // Directed vectors, one at a time with out_ready high.
    foreach (dtab[i]) begin
      dir_exp.res = dtab[i].res;
      dir_exp.fl  = dtab[i].fl;
      dir_pend = 1;
      step(1, dtab[i].op, dtab[i].a[15:0], dtab[i].b[15:0], 1);
      check("dir_accepted", dir_pend, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
    end
    drain();

    // Random streams with random back-pressure; tags restart at 0 and wrap.
    do_reset();
    stream(10);
    drain();
    stream(18);
    drain();
    check("tag_after_28", tag_model, 28 % 16);

    // Reset with two instructions in flight.
    step(1, 4'd0, 16'h0001, 16'h0002, 0);
    step(1, 4'd1, 16'h0009, 16'h0004, 0);
    step(1, 4'd2, 16'h00FF, 16'h0F0F, 0);
    check("two_in_flight", sb.size(), 2);
    do_reset();
    step(1, 4'd0, 16'h0003, 16'h0004, 1);
    drain();

    // 32-bit regression on the second instance.
    foreach (wtab[i]) begin
      @(negedge clk);
      bus32.in_valid = 1; bus32.opcode = wtab[i].op;
      bus32.operand1 = wtab[i].a; bus32.operand2 = wtab[i].b;
      bus32.out_ready = 1;
      #1;
      check("w32_in_ready", bus32.in_ready, 1);
      @(negedge clk);
      bus32.in_valid = 0;
      @(negedge clk);
      #1;
      check("w32_out_valid", bus32.out_valid, 1);
      check("w32_result", bus32.result, wtab[i].res);
      check("w32_flags", {bus32.illegal_op, bus32.ovf_flag, bus32.carry_flag,
                          bus32.neg_flag, bus32.zero_flag}, wtab[i].fl);
      check("w32_tag", bus32.res_tag, i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu_pipe.md
# riscv_alu_pipe

Parametrised, two-stage pipelined execute unit for the 16-bit RISC CPU. It generalises the single-cycle ALU to any power-of-two data width and a larger opcode set, and adds full status flags, illegal-opcode detection and a valid/ready handshake on both sides with back-pressure. It also tags every result with the sequence number of the instruction that produced it. It sits between the decode/operand-fetch logic (upstream) and register-file writeback (downstream).

## Interface
- WIDTH, 16, data width in bits; must be a power of two, ≥4
- TAG_W, 16, width of the instruction sequence counter/tag
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  unit accepts this cycle
- opcode  in  4  operation select
- operand1  in  WIDTH  first operand (A)
- operand2  in  WIDTH  second operand (B)
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream consumes this cycle
- result  out  WIDTH  ALU result
- zero_flag  out  1  result == 0
- neg_flag  out  1  result[WIDTH-1]
- carry_flag  out  1  ADD carry-out / SUB/SLT/SLTU borrow
- ovf_flag  out  1  signed overflow (ADD/SUB only)
- illegal_op  out  1  opcode was not defined
- res_tag  out  TAG_W  sequence number of the instruction that produced the result

## Operation
- Accept = in_valid && in_ready. On accept, stage 1 (S1) captures opcode, operands and the tag counter value; the tag counter then increments, wrapping modulo 2^TAG_W.
- S1 → S2 advance when S1 is valid and (S2 is empty or out_ready). S2 registers result, flags and tag. Output = S2 registers.
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU (unsigned, result 1/0), 10–15 illegal.
- Shift amount = operand2[log2(WIDTH)-1:0]; upper bits of operand2 are ignored.
- ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum; ovf = operands of the same sign and result of the opposite sign.
- SUB: carry = borrow (A < B unsigned); ovf = operands of different sign and result sign ≠ A sign.
- SLT/SLTU: carry = borrow of A−B; ovf = 0.
- Logic and shift ops: carry = ovf = 0.
- zero_flag and neg_flag are derived from the final result for every legal op.
- Illegal opcode: result = 0, zero/neg/carry/ovf = 0, illegal_op = 1. The instruction still flows through the pipeline and consumes a tag.

## Timing
- Reset values: out_valid 0, result 0, all flags 0, illegal_op 0, res_tag 0, tag counter 0, S1 empty.
- While reset is high, in_ready = 0 and inputs are ignored. Reset mid-operation discards both in-flight instructions; no partial result is presented.
- in_ready = !reset && (S1 empty or S1 advances this cycle). This is a combinational path from out_ready to in_ready; it is accepted by design.
- Latency: accept at cycle N → out_valid at N+2 when not stalled.
- Throughput: 1 instruction/cycle with out_ready held high.
- Stall: with out_valid=1 and out_ready=0, result, flags and res_tag stay stable. S1 fills, then in_ready drops. No instruction is lost or duplicated.
- Simultaneous events: in one cycle, S2 may drain, S1 may advance and a new instruction may be accepted.
- Tag wrap: after tag 2^TAG_W−1 the next tag is 0.

## Structure
- Package riscv_alu_pkg holds the opcode localparams/enum (OP_ADD … OP_SLTU) and a flags struct {zero, neg, carry, ovf, illegal}.
- Sub-module riscv_alu_core: purely combinational, parametrised by WIDTH, maps opcode/A/B to result and flags. The pipeline wrapper holds the registers, handshake and tag counter.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001 → result 0x8000, ovf 1, neg 1, carry 0, zero 0, at 2 cycles after accept.
- SUB 0x0003−0x0005 → result 0xFFFE, carry 1, ovf 0. SUB 5−5 → result 0, zero 1.
- SRA 0x8000 by operand2=0x0014 (shift 4) → 0xF800. SLT 0xFFFF vs 0x0001 → 1; SLTU → 0. Opcode 12 → result 0, illegal_op 1.
- Back-to-back stream of 10 ops with out_ready toggled randomly → all results in order, res_tag 0..9, no drops or duplicates; in_ready falls only when S1 and S2 are both full and stalled.
- TAG_W=4: stream 18 ops → tags wrap 15→0; assert reset with 2 ops in flight → out_valid 0 next cycle, next accepted op gets tag 0.
- WIDTH=32 regression: ADD 0xFFFFFFFF+1 → result 0, carry 1, zero 1.
